// File: rtl/life_pkg.sv
// Shared types and constants for the Life display path: grid geometry,
// plot colours, queue FSM states and the packed cell-change event record.
package life_pkg;

   localparam int GRID_W = 160;
   localparam int GRID_H = 120;
   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int COL_W  = 3;

   localparam logic [X_W-1:0]   X_LAST    = 8'd159;
   localparam logic [Y_W-1:0]   Y_LAST    = 7'd119;
   localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
   localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           alive;
   } cell_evt_t;

   localparam int EVT_W = $bits(cell_evt_t);

   function automatic logic in_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x <= X_LAST) && (y <= Y_LAST);
   endfunction

endpackage

// File: rtl/life_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-around pointers;
// head entry is visible combinationally on pop_data while not empty.
module life_sync_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/life_plot_queue.sv
// Buffers Life cell-change events and drives the VGA plot port one pixel per
// clock; a clear request sweeps the whole canvas before the queue drains.
module life_plot_queue
   import life_pkg::*;
#(
   parameter int               DEPTH        = 16,
   parameter logic [COL_W-1:0] ALIVE_COLOUR = COL_WHITE,
   parameter logic [COL_W-1:0] DEAD_COLOUR  = COL_BLACK,
   localparam int              CW           = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [X_W-1:0]   in_x,
   input  logic [Y_W-1:0]   in_y,
   input  logic             in_alive,
   input  logic             clear_req,
   output logic             clear_busy,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [COL_W-1:0] colour,
   output logic             plot,
   output logic             overflow,
   output logic             range_err,
   output logic [CW-1:0]    count
);

   state_t         state_q, state_d;
   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   cell_evt_t      in_evt, head;
   logic           fifo_full, fifo_empty;
   logic           in_range, push, pop, sweep_start, sweep_last;

   assign in_evt     = '{x: in_x, y: in_y, alive: in_alive};
   assign in_range   = in_grid(in_x, in_y);
   assign in_ready   = ~fifo_full;
   assign push       = in_valid & in_ready & in_range;
   assign sweep_last = (cx == X_LAST) && (cy == Y_LAST);
   assign clear_busy = (state_q == ST_CLEAR);

   life_sync_fifo #(.WIDTH(EVT_W), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (in_evt),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // Clear request wins over a pending pop; the queue is only read in RUN.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      sweep_start = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (clear_req) begin
               state_d     = ST_CLEAR;
               sweep_start = 1'b1;
            end else begin
               pop = ~fifo_empty;
            end
         end
         ST_CLEAR: begin
            if (sweep_last) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cx        <= '0;
         cy        <= '0;
         x         <= '0;
         y         <= '0;
         colour    <= '0;
         plot      <= 1'b0;
         overflow  <= 1'b0;
         range_err <= 1'b0;
      end else begin
         range_err <= in_valid & in_ready & ~in_range;
         if (in_valid & ~in_ready) overflow <= 1'b1;

         case (state_q)
            ST_RUN: begin
               if (sweep_start) begin
                  cx   <= '0;
                  cy   <= '0;
                  plot <= 1'b0;
               end else if (pop) begin
                  x      <= head.x;
                  y      <= head.y;
                  colour <= head.alive ? ALIVE_COLOUR : DEAD_COLOUR;
                  plot   <= 1'b1;
               end else begin
                  plot <= 1'b0;
               end
            end
            ST_CLEAR: begin
               x      <= cx;
               y      <= cy;
               colour <= DEAD_COLOUR;
               plot   <= 1'b1;
               // Raster advance; counters land back at the origin after the last pixel.
               if (cx == X_LAST) begin
                  cx <= '0;
                  cy <= sweep_last ? '0 : cy + Y_W'(1);
               end else begin
                  cx <= cx + X_W'(1);
               end
            end
            default: plot <= 1'b0;
         endcase
      end
   end

endmodule
